// File: rtl/rat_div_arb.sv
// Round-robin arbiter and sequencer that shares one rat_div datapath among NREQ requesters.
// Optional feature macro RAT_DIV_ARB_ZERO_CHECK_EN: zero-divisor requests bypass the datapath with resp_err.
module rat_div_arb #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_l_num,
  input  logic [NREQ*WIDTH-1:0] req_l_den,
  input  logic [NREQ*WIDTH-1:0] req_r_num,
  input  logic [NREQ*WIDTH-1:0] req_r_den,
  output logic [WIDTH-1:0]      dp_l_num,
  output logic [WIDTH-1:0]      dp_l_den,
  output logic [WIDTH-1:0]      dp_r_num,
  output logic [WIDTH-1:0]      dp_r_den,
  input  logic [WIDTH-1:0]      dp_s_num,
  input  logic [WIDTH-1:0]      dp_s_den,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_num,
  output logic [WIDTH-1:0]      resp_den,
  output logic                  resp_err,
  output logic                  busy
);

  // state | meaning
  // IDLE  | arbitrate; on grant latch operands
  // ISSUE | dp_* stable, rat_div registers them
  // WAIT  | dp_s_* valid, capture quotient
  // RESP  | hold response until resp_ready
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [IDW-1:0]   last;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   grant_idx;
  logic             grant_found;
  logic [WIDTH-1:0] sel_l_num;
  logic [WIDTH-1:0] sel_l_den;
  logic [WIDTH-1:0] sel_r_num;
  logic [WIDTH-1:0] sel_r_den;

  // search starts just after the last winner so each requester waits at most NREQ grants
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_l_num = '0;
    sel_l_den = '0;
    sel_r_num = '0;
    sel_r_den = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_l_num = req_l_num[i*WIDTH +: WIDTH];
        sel_l_den = req_l_den[i*WIDTH +: WIDTH];
        sel_r_num = req_r_num[i*WIDTH +: WIDTH];
        sel_r_den = req_r_den[i*WIDTH +: WIDTH];
      end
    end
  end

  assign req_ready = (rst_n && state == IDLE && grant_found) ? (NREQ'(1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= IDW'(NREQ - 1);
      dp_l_num   <= '0;
      dp_l_den   <= '0;
      dp_r_num   <= '0;
      dp_r_den   <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_num   <= '0;
      resp_den   <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            resp_id <= grant_idx;
            last    <= grant_idx;
            busy    <= 1'b1;
`ifdef RAT_DIV_ARB_ZERO_CHECK_EN
            if (sel_r_num == '0) begin
              resp_num   <= '0;
              resp_den   <= '0;
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              dp_l_num <= sel_l_num;
              dp_l_den <= sel_l_den;
              dp_r_num <= sel_r_num;
              dp_r_den <= sel_r_den;
              state    <= ISSUE;
            end
`else
            dp_l_num <= sel_l_num;
            dp_l_den <= sel_l_den;
            dp_r_num <= sel_r_num;
            dp_r_den <= sel_r_den;
            state    <= ISSUE;
`endif
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          resp_num   <= dp_s_num;
          resp_den   <= dp_s_den;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rat_div_arb.sv
// Self-checking bench for rat_div_arb: directed scenarios plus random traffic against a
// timeline reference model (grant at T, response at T+3, or T+1 for a zero divisor when enabled).
module tb_rat_div_arb;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int M_RAND = 0;
  localparam int M_ALL  = 1;
  localparam int M_HOLD = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_l_num = '0, req_l_den = '0, req_r_num = '0, req_r_den = '0;
  logic [WIDTH-1:0]      dp_l_num, dp_l_den, dp_r_num, dp_r_den;
  logic [WIDTH-1:0]      dp_s_num = '0, dp_s_den = '0;
  logic                  resp_valid;
  logic                  resp_ready = 1'b0;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_num, resp_den;
  logic                  resp_err;
  logic                  busy;

  always #5 clk = ~clk;

  rat_div_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_l_num(req_l_num), .req_l_den(req_l_den), .req_r_num(req_r_num), .req_r_den(req_r_den),
    .dp_l_num(dp_l_num), .dp_l_den(dp_l_den), .dp_r_num(dp_r_num), .dp_r_den(dp_r_den),
    .dp_s_num(dp_s_num), .dp_s_den(dp_s_den),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_num(resp_num), .resp_den(resp_den), .resp_err(resp_err), .busy(busy)
  );

  // the shared rat_div: one register stage, products truncated to WIDTH
  always_ff @(posedge clk) begin
    dp_s_num <= dp_l_num * dp_r_den;
    dp_s_den <= dp_l_den * dp_r_num;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [WIDTH-1:0] op_l[NREQ], op_ld[NREQ], op_rn[NREQ], op_rd[NREQ];
  bit               m_idle = 1'b1;
  int               m_last = NREQ - 1;
  int               m_gcyc, m_rcyc, m_id;
  logic [WIDTH-1:0] m_num, m_den;
  bit               m_err;
  logic [WIDTH-1:0] m_dp[4] = '{default: '0};
  int               acc = -1;
  int               bp_left = 0;
  int               grants[$];
  int               gcycles[$];
  int               hs_cycles[$];
  logic [WIDTH-1:0] obs_num, obs_den;
  logic             obs_err;
  logic [NREQ-1:0]  last_rdy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic new_ops(input int i);
    op_l[i]  = $urandom();
    op_ld[i] = $urandom();
    op_rn[i] = ($urandom_range(0, 7) == 0) ? '0 : $urandom();
    op_rd[i] = $urandom();
  endtask

  task automatic set_ops(input int i, input logic [WIDTH-1:0] l, ld, rn, rd);
    op_l[i] = l; op_ld[i] = ld; op_rn[i] = rn; op_rd[i] = rd;
    req_valid[i] = 1'b1;
  endtask

  task automatic pack_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_l_num[i*WIDTH +: WIDTH] = op_l[i];
      req_l_den[i*WIDTH +: WIDTH] = op_ld[i];
      req_r_num[i*WIDTH +: WIDTH] = op_rn[i];
      req_r_den[i*WIDTH +: WIDTH] = op_rd[i];
    end
  endtask

  task automatic accept(input int g);
    bit zero;
    zero = 1'b0;
`ifdef RAT_DIV_ARB_ZERO_CHECK_EN
    zero = (op_rn[g] == '0);
`endif
    m_idle = 1'b0; m_gcyc = cyc; m_last = g; m_id = g; acc = g;
    grants.push_back(g);
    gcycles.push_back(cyc);
    if (zero) begin
      m_num = '0; m_den = '0; m_err = 1'b1; m_rcyc = cyc + 1;
    end else begin
      m_num = op_l[g] * op_rd[g];
      m_den = op_ld[g] * op_rn[g];
      m_err = 1'b0;
      m_rcyc = cyc + 3;
      m_dp[0] = op_l[g]; m_dp[1] = op_ld[g]; m_dp[2] = op_rn[g]; m_dp[3] = op_rd[g];
    end
  endtask

  // one clock cycle: drive at the falling edge, compare 1 ns later, model the rising edge
  task automatic tick(input int mode);
    int g;
    bit exp_rv;
    logic [NREQ-1:0] exp_rdy;
    if (acc >= 0) req_valid[acc] = 1'b0;
    acc = -1;
    for (int i = 0; i < NREQ; i++)
      if (!req_valid[i] && (mode == M_ALL || (mode == M_RAND && $urandom_range(0, 2) == 0))) begin
        new_ops(i);
        req_valid[i] = 1'b1;
      end
    exp_rv = !m_idle && (cyc >= m_rcyc);
    if (mode == M_RAND) resp_ready = 1'($urandom_range(0, 1));
    else if (bp_left > 0 && exp_rv) begin
      resp_ready = 1'b0;
      bp_left--;
    end else resp_ready = 1'b1;
    pack_ops();
    #1;
    last_rdy = req_ready;
    check("dp_l_num", dp_l_num, m_dp[0]);
    check("dp_l_den", dp_l_den, m_dp[1]);
    check("dp_r_num", dp_r_num, m_dp[2]);
    check("dp_r_den", dp_r_den, m_dp[3]);
    if (m_idle) begin
      g = rr_pick(req_valid, m_last);
      exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
      check("req_ready", req_ready, exp_rdy);
      check("resp_valid_idle", resp_valid, 0);
      check("busy_idle", busy, 0);
      if (g >= 0) accept(g);
    end else begin
      check("req_ready_busy", req_ready, 0);
      check("busy", busy, 1);
      check("resp_valid", resp_valid, exp_rv);
      if (exp_rv) begin
        check("resp_id", resp_id, m_id);
        check("resp_num", resp_num, m_num);
        check("resp_den", resp_den, m_den);
        check("resp_err", resp_err, m_err);
        if (resp_ready) m_idle = 1'b1;
      end
    end
    if (resp_valid && resp_ready) begin
      hs_cycles.push_back(cyc);
      obs_num = resp_num; obs_den = resp_den; obs_err = resp_err;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) new_ops(i);
    req_valid = '1;
    resp_ready = 1'b1;
    pack_ops();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cyc++;
      check("rst_req_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_dp", {dp_l_num ^ dp_l_den, dp_r_num | dp_r_den}, 0);
      check("rst_resp", {resp_num, resp_den}, 0);
      check("rst_id_err", {resp_id, resp_err}, 0);
    end
    req_valid = '0;
    rst_n = 1'b1;
    m_idle = 1'b1; m_last = NREQ - 1; acc = -1; bp_left = 0;
    m_dp = '{default: '0};
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && !(m_idle && req_valid == '0); t++) tick(M_HOLD);
    check("drain_done", m_idle && req_valid == '0, 1);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      op_l[i] = '0; op_ld[i] = '0; op_rn[i] = '0; op_rd[i] = '0;
    end
    do_reset(2);
    tick(M_HOLD);
    tick(M_HOLD);

    // round robin from reset: 0,1,2,3,0 spaced 4 cycles
    grants.delete(); gcycles.delete();
    for (int t = 0; t < 20; t++) tick(M_ALL);
    check("rr_count", grants.size() >= 5, 1);
    if (grants.size() >= 5)
      for (int k = 0; k < 5; k++) begin
        check("rr_order", grants[k], k % NREQ);
        if (k > 0) check("rr_spacing", gcycles[k] - gcycles[k-1], 4);
      end
    drain();

    // single request on requester 2: 3/4 / 5/7 -> 21/20
    grants.delete(); gcycles.delete(); hs_cycles.delete();
    set_ops(2, 3, 4, 5, 7);
    drain();
    check("single_grants", grants.size() == 1 && hs_cycles.size() == 1, 1);
    if (grants.size() == 1 && hs_cycles.size() == 1) begin
      check("single_id", grants[0], 2);
      check("single_latency", hs_cycles[0] - gcycles[0], 3);
    end
    check("single_num", obs_num, 21);
    check("single_den", obs_den, 20);
    check("single_err", obs_err, 0);

    // back-pressure: 5 low cycles in RESP with another requester waiting
    grants.delete(); gcycles.delete(); hs_cycles.delete();
    set_ops(1, $urandom(), $urandom(), 9, $urandom());
    set_ops(3, $urandom(), $urandom(), 11, $urandom());
    bp_left = 5;
    drain();
    check("bp_grants", grants.size() == 2 && hs_cycles.size() == 2, 1);
    if (grants.size() == 2 && hs_cycles.size() == 2) begin
      check("bp_first", grants[0], 3);
      check("bp_latency", hs_cycles[0] - gcycles[0], 8);
      check("bp_next_grant", gcycles[1] - hs_cycles[0], 1);
    end

    // zero divisor on requester 1: 1/2 / 0/3
    grants.delete(); gcycles.delete(); hs_cycles.delete();
    set_ops(1, 1, 2, 0, 3);
    drain();
    check("zero_hs", grants.size() == 1 && hs_cycles.size() == 1, 1);
`ifdef RAT_DIV_ARB_ZERO_CHECK_EN
    if (hs_cycles.size() == 1 && gcycles.size() == 1) check("zero_latency", hs_cycles[0] - gcycles[0], 1);
    check("zero_num", obs_num, 0);
    check("zero_den", obs_den, 0);
    check("zero_err", obs_err, 1);
`else
    if (hs_cycles.size() == 1 && gcycles.size() == 1) check("zero_latency", hs_cycles[0] - gcycles[0], 3);
    check("zero_num", obs_num, 3);
    check("zero_den", obs_den, 0);
    check("zero_err", obs_err, 0);
`endif

    // random traffic
    for (int t = 0; t < 400; t++) tick(M_RAND);
    drain();

    // reset while in WAIT, then requester 0 wins over requester 2
    set_ops(3, $urandom(), $urandom(), 13, $urandom());
    for (int t = 0; t < 10 && !(!m_idle && cyc == m_gcyc + 2); t++) tick(M_HOLD);
    check("reached_wait", !m_idle && cyc == m_gcyc + 2, 1);
    do_reset(1);
    for (int t = 0; t < 4; t++) tick(M_HOLD);
    set_ops(0, $urandom(), $urandom(), 5, $urandom());
    set_ops(2, $urandom(), $urandom(), 6, $urandom());
    tick(M_HOLD);
    check("post_reset_grant", last_rdy, 4'b0001);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rat_div_arb.md
# rat_div_arb

Round-robin arbiter and sequencer that shares one `rat_div` rational-division datapath between `NREQ` requesters. It grants one request at a time and registers the operands into the datapath. It then waits out the datapath's one-cycle register latency, captures the quotient, and returns it with the requester ID over a valid/ready response channel. It sits between the rational-arithmetic clients and the single `rat_div` instance.

## Interface
- `WIDTH`, 32: numerator/denominator width; matches `rat_div` `WIDTH`.
- `NREQ`, 4: requester count, 2..8.
- `IDW`, `$clog2(NREQ)`: requester-ID width.

Ports:
- `clk`  in  1  the only clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  NREQ  bit i: requester i presents operands.
- `req_ready`  out  NREQ  bit i: request i accepted this cycle (one-hot or zero).
- `req_l_num`, `req_l_den`, `req_r_num`, `req_r_den`  in  NREQ*WIDTH each  operands; requester i occupies slice [i*WIDTH +: WIDTH].
- `dp_l_num`, `dp_l_den`, `dp_r_num`, `dp_r_den`  out  WIDTH each  registered operands to `rat_div`.
- `dp_s_num`, `dp_s_den`  in  WIDTH each  `rat_div` outputs.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_id`  out  IDW  requester the response belongs to.
- `resp_num`, `resp_den`  out  WIDTH each  quotient, `l/r = (l_num*r_den)/(l_den*r_num)`, truncated to WIDTH bits.
- `resp_err`  out  1  divide-by-zero flag.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP.
- IDLE:
  - Grant g is the first requester with `req_valid` high, searched round-robin starting at `last+1` (mod NREQ).
  - `req_ready[g]` goes high combinationally; all other bits stay low.
  - If no `req_valid` is high, `req_ready` is 0 and the FSM stays in IDLE.
  - On a grant: latch g's four operands into the `dp_*` registers, set `resp_id`=g and `last`=g, then go to ISSUE.
- ISSUE: the `dp_*` operands are stable and `rat_div` registers them on this edge. Go to WAIT.
- WAIT: `dp_s_num`/`dp_s_den` are valid. Capture them into `resp_num`/`resp_den`, clear `resp_err`, go to RESP.
- RESP:
  - `resp_valid` is high; `resp_*` are held stable until `resp_ready` is high.
  - When `resp_valid && resp_ready`, go to IDLE.
  - No new grant is issued in the same cycle as the handshake.
- `req_ready` is 0 in every state except IDLE; requesters hold their operands until their ready bit is seen.
- Fairness: a requester that keeps `req_valid` high is granted within NREQ grants.
- Arithmetic: products are truncated to the low WIDTH bits, exactly as `rat_div` produces them. No sign handling and no reduction.
- Reset values (`rst_n`=0 at an edge):
  - State = IDLE, `last` = NREQ-1, so requester 0 has first priority.
  - `dp_*` = 0, `resp_num`/`resp_den`/`resp_id`/`resp_err` = 0.
  - `resp_valid` = 0, `busy` = 0.
  - `req_ready` is forced to 0 while `rst_n` is low.
- Reset mid-operation discards any in-flight request without a response. The requester must re-present it.

## Timing
- The request is accepted in cycle T (`req_valid[g] && req_ready[g]`).
- ISSUE is T+1, WAIT is T+2, and `resp_valid` rises at T+3.
- Best-case issue interval is 4 cycles, i.e. `resp_ready` held high.
- Back-pressure: each cycle `resp_ready` is low extends RESP by one cycle.
- With the zero check compiled in, a zero-divisor response has a latency of 1 (`resp_valid` at T+1).

## Configuration
- Macro: `RAT_DIV_ARB_ZERO_CHECK_EN`.
- Defined:
  - In IDLE, a granted request with `r_num`==0 is accepted normally but skips ISSUE/WAIT and goes straight to RESP.
  - Response fields: `resp_num`=0, `resp_den`=0, `resp_err`=1.
  - The `dp_*` registers are not updated.
- Undefined:
  - Every request goes through the datapath, and `resp_err` is tied to 0.
  - A zero `r_num` yields `resp_den`=0 from `rat_div`.

## Test plan
- Reset then idle: with `rst_n` low for 2 cycles, all outputs are 0. After release with no `req_valid`, `busy`=0 and `req_ready`=0.
- Single request on requester 2 (WIDTH=32), operands 3/4 ÷ 5/7, accepted at T:
  - `dp_*` = 3, 4, 5, 7 during T+1.
  - At T+3: `resp_valid`=1, `resp_id`=2, `resp_num`=21, `resp_den`=20, `resp_err`=0.
- Round robin: all four `req_valid` held high and `resp_ready`=1 → grant order 0, 1, 2, 3, 0, with responses 4 cycles apart.
- Back-pressure: `resp_ready` low for 5 cycles in RESP → `resp_*` stay constant, all `req_ready` stay 0, and no new grant is issued until 1 cycle after the handshake.
- Zero divisor, requester 1, 1/2 ÷ 0/3:
  - Macro defined: `resp_valid` at T+1 with `resp_err`=1, num=0, den=0.
  - Macro undefined: `resp_valid` at T+3 with `resp_num`=3, `resp_den`=0, `resp_err`=0.
- Reset in WAIT: drive `rst_n`=0 for 1 cycle → FSM returns to IDLE, `resp_valid` never asserts for that request, and the next grant goes to requester 0 if it is valid.
